proj_minhash_sig: RTL and testbench

Downstream consumer of the feature-map ping-pong buffer. Each beat it takes one shingle: SHINGLE_BYTES consecutive bytes, with the lowest-address byte in the MSBs. It hashes the shingle with NUM_HASH independent multiply-add hashes and keeps a running per-hash minimum over a frame. At frame end it emits the MinHash signature as NUM_HASH words over a valid/ready stream.

---
 rtl/proj_minhash_sig.sv | 154 +++++++++++++++
 tb/tb_proj_minhash_sig.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_minhash_sig.sv
// proj_minhash_sig: streaming MinHash signature over framed shingles.
// The per-hash running minimum is updated one cycle after accept; the signature is emitted on a valid/ready stream.
module proj_minhash_sig #(
  parameter int                   SHINGLE_BYTES = 2,
  parameter int                   DATA_BITS     = 8,
  parameter int                   NUM_HASH      = 4,
  parameter int                   HASH_BITS     = 16,
  parameter logic [HASH_BITS-1:0] A_BASE        = 16'h9E37,
  parameter logic [HASH_BITS-1:0] A_STEP        = 16'h0D3A,
  parameter logic [HASH_BITS-1:0] B_BASE        = 16'h7F4A,
  parameter logic [HASH_BITS-1:0] B_STEP        = 16'h1111
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SHINGLE_BYTES*DATA_BITS-1:0]   in_shingle,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [HASH_BITS-1:0]                 out_data,
  output logic [$clog2(NUM_HASH)-1:0]          out_idx,
  output logic                                 out_valid,
  output logic                                 out_last,
  input  logic                                 out_ready
);

  localparam int                 IDX_W    = $clog2(NUM_HASH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_HASH - 1);
  localparam logic [1:0]         ST_ACCUM = 2'd0;
  localparam logic [1:0]         ST_FLUSH = 2'd1;
  localparam logic [1:0]         ST_EMIT  = 2'd2;

  function automatic logic [HASH_BITS-1:0] coef_a(input int h);
    return (A_BASE + HASH_BITS'(h) * A_STEP) | {{(HASH_BITS-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [HASH_BITS-1:0] coef_b(input int h);
    return B_BASE + HASH_BITS'(h) * B_STEP;
  endfunction

  logic [HASH_BITS-1:0] key_s;
  logic [HASH_BITS-1:0] hash_s [NUM_HASH];
  logic [HASH_BITS-1:0] hash_q [NUM_HASH];
  logic [HASH_BITS-1:0] min_q  [NUM_HASH];
  logic [HASH_BITS-1:0] min_d  [NUM_HASH];
  logic                 s1_valid_q;
  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 accept_s, out_hs_s, last_hs_s;
  logic                 in_ready_q, out_valid_q, out_last_q;
  logic [HASH_BITS-1:0] out_data_q;

  assign key_s     = HASH_BITS'(in_shingle);
  assign accept_s  = in_valid && (state_q == ST_ACCUM);
  assign out_hs_s  = (state_q == ST_EMIT) && out_ready;
  assign last_hs_s = out_hs_s && (idx_q == LAST_IDX);

  // Multiply-add hash per index; product keeps only the low HASH_BITS.
  always_comb begin
    for (int h = 0; h < NUM_HASH; h++) begin
      hash_s[h] = coef_a(h) * key_s + coef_b(h);
    end
  end

  // Running minimum; ties keep the old value, last handshake re-seeds to all-ones.
  always_comb begin
    for (int h = 0; h < NUM_HASH; h++) begin
      if (last_hs_s) begin
        min_d[h] = {HASH_BITS{1'b1}};
      end else if (s1_valid_q && (hash_q[h] < min_q[h])) begin
        min_d[h] = hash_q[h];
      end else begin
        min_d[h] = min_q[h];
      end
    end
  end

  // Frame control: accumulate, one flush cycle for the last min update, then emit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s && in_last) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        state_d = ST_EMIT;
        idx_d   = {IDX_W{1'b0}};
      end
      ST_EMIT: begin
        if (last_hs_s) begin
          state_d = ST_ACCUM;
          idx_d   = {IDX_W{1'b0}};
        end else if (out_hs_s) begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Stage 1 hash capture and stage 2 minimum state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      for (int h = 0; h < NUM_HASH; h++) begin
        hash_q[h] <= {HASH_BITS{1'b0}};
        min_q[h]  <= {HASH_BITS{1'b1}};
      end
    end else begin
      s1_valid_q <= accept_s;
      for (int h = 0; h < NUM_HASH; h++) begin
        if (accept_s) begin
          hash_q[h] <= hash_s[h];
        end
        min_q[h] <= min_d[h];
      end
    end
  end

  // FSM and registered output stage; out_data is loaded from the next-state minimum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      idx_q       <= {IDX_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {HASH_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_EMIT);
      out_last_q  <= (state_d == ST_EMIT) && (idx_d == LAST_IDX);
      out_data_q  <= (state_d == ST_EMIT) ? min_d[idx_d] : {HASH_BITS{1'b0}};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_proj_minhash_sig.sv
// Self-checking bench for proj_minhash_sig: random frames against a plain-arithmetic MinHash model.
module tb_proj_minhash_sig;

  localparam int NH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_shingle = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;

  int passes = 0;
  int checks = 0;

  logic [15:0] shin    [2][64];
  int          nbeats  [2];
  logic [15:0] exp_sig [2][NH];

  proj_minhash_sig dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_shingle(in_shingle),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_hash(input int h, input logic [15:0] x);
    int unsigned a, b, r;
    a = ((32'h9E37 + 32'(h) * 32'h0D3A) & 32'hFFFF) | 32'd1;
    b = (32'h7F4A + 32'(h) * 32'h1111) & 32'hFFFF;
    r = a * 32'(x) + b;
    return r[15:0];
  endfunction

  task automatic build_model(input int slot);
    logic [15:0] m, v;
    for (int h = 0; h < NH; h++) begin
      m = 16'hFFFF;
      for (int i = 0; i < nbeats[slot]; i++) begin
        v = ref_hash(h, shin[slot][i]);
        if (v < m) m = v;
      end
      exp_sig[slot][h] = m;
    end
  endtask

  task automatic set_zero_frame(input int slot);
    nbeats[slot]     = 1;
    shin[slot][0]    = 16'h0000;
    exp_sig[slot][0] = 16'h7F4A;
    exp_sig[slot][1] = 16'h905B;
    exp_sig[slot][2] = 16'hA16C;
    exp_sig[slot][3] = 16'hB27D;
  endtask

  task automatic rand_frame(input int slot, input int n, input int pool);
    logic [15:0] vals [4];
    for (int k = 0; k < 4; k++) vals[k] = 16'($urandom);
    nbeats[slot] = n;
    for (int i = 0; i < n; i++) begin
      if (pool > 0) shin[slot][i] = vals[$urandom_range(pool - 1)];
      else shin[slot][i] = 16'($urandom);
    end
    build_model(slot);
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the last beat.
  task automatic send_frame(input int slot, input int gap_pct);
    int budget;
    bit acc;
    for (int i = 0; i < nbeats[slot]; i++) begin
      while (32'($urandom_range(99)) < 32'(gap_pct)) begin
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_shingle = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid   = 1'b1;
      in_shingle = shin[slot][i];
      in_last    = (i == nbeats[slot] - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("in_ready_flush", 32'(in_ready), 32'd0);
  endtask

  // mode 0: always ready, 1: low 5 cycles then toggling, 2: random.
  task automatic collect(input int slot, input int mode);
    int cnt, cyc;
    bit done;
    cnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      if (cnt == NH) begin
        done = 1'b1;
      end else begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc < 5) ? 1'b0 : ((cyc % 2) == 1);
          default: out_ready = 1'($urandom_range(1));
        endcase
        @(negedge clk);
        if (cyc == 0) check_eq("sig_latency", 32'(out_valid), 32'd1);
        if (out_valid) begin
          check_eq("out_idx", 32'(out_idx), 32'(cnt));
          check_eq("out_data", 32'(out_data), 32'(exp_sig[slot][cnt]));
          check_eq("out_last", 32'(out_last), 32'(cnt == NH - 1));
          check_eq("in_ready_emit", 32'(in_ready), 32'd0);
          if (out_ready) cnt++;
        end
        cyc++;
      end
    end
    if (!done) check_eq("collect_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    check_eq("in_ready_after", 32'(in_ready), 32'd1);
    check_eq("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_values();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_out_idx", 32'(out_idx), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat x=0 frame: signature is just the addends.
    set_zero_frame(0);
    send_frame(0, 0);
    collect(0, 0);

    // Two-beat frame {0, 1}.
    nbeats[0] = 2; shin[0][0] = 16'h0000; shin[0][1] = 16'h0001;
    build_model(0);
    check_eq("model_idx0", 32'(exp_sig[0][0]), 32'h1D81);
    send_frame(0, 0);
    collect(0, 0);

    // Same frame under back-pressure.
    send_frame(0, 0);
    collect(0, 1);

    // Back-to-back: second frame waits while the first signature drains.
    rand_frame(0, 5, 0);
    rand_frame(1, 7, 0);
    send_frame(0, 0);
    fork
      send_frame(1, 0);
      collect(0, 2);
    join
    collect(1, 0);

    // Gaps and ties: repeated shingles drawn from a small pool.
    rand_frame(0, 16, 3);
    send_frame(0, 30);
    collect(0, 2);
    for (int f = 0; f < 6; f++) begin
      rand_frame(0, 1 + $urandom_range(19), (f % 2 == 0) ? 2 : 0);
      send_frame(0, 25);
      collect(0, 2);
    end

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_last    = 1'b0;
      in_shingle = 16'($urandom);
      @(posedge clk); #1;
    end
    pulse_reset();
    set_zero_frame(0);
    send_frame(0, 0);
    collect(0, 0);

    // Reset mid-emit.
    rand_frame(1, 4, 0);
    send_frame(1, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pulse_reset();
    set_zero_frame(0);
    send_frame(0, 0);
    collect(0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
